// File: rtl/mux_stream_sel_pkg.sv
// ----------------------------------------------------------------------------
// mux_stream_sel_pkg
//   Shared constants and helpers for the N-way stream selector.
//   - MODE_SEL / MODE_RR : selection mode encodings for the MODE parameter
//   - clog2()            : ceiling log2, used to derive the select/source width
// ----------------------------------------------------------------------------
package mux_stream_sel_pkg;

  localparam int MODE_SEL = 0;  // explicit channel select via sel
  localparam int MODE_RR  = 1;  // round-robin among valid channels

  // Ceiling log2 with a floor of 1, so a 2-channel build still has a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_stream_sel_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_stream_sel_rr_arbiter
//   Combinational round-robin arbiter. Scans ptr+1, ptr+2, ... (mod N) and
//   grants the first requesting channel.
// Ports
//   req        in   N     per-channel request
//   ptr        in   SELW  index of the most recently granted channel
//   en         in   1     grants are suppressed when low
//   grant      out  N     one-hot grant (or zero)
//   grant_idx  out  SELW  index of the granted channel (0 when no grant)
// ----------------------------------------------------------------------------
module mux_stream_sel_rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  // One extra bit so ptr + k (at most 2N-1) never overflows before the wrap.
  logic [SELW:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr} + (SELW+1)'(k);
      // A single subtraction is enough to wrap since ptr < N and k <= N.
      if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
      if (en && !found && req[cand[SELW-1:0]]) begin
        grant[cand[SELW-1:0]] = 1'b1;
        grant_idx             = cand[SELW-1:0];
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_stream_sel.sv
// ----------------------------------------------------------------------------
// mux_stream_sel
//   N-way, WIDTH-bit selector with a registered output stage and valid/ready
//   handshake on both sides. MODE 0 selects the channel named by sel; MODE 1
//   round-robins over the valid channels.
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready (combinational from out_ready)
//   sel        in   SELW     channel index, MODE 0 only
//   out_data   out  WIDTH    registered data
//   out_src    out  SELW     registered index of the supplying channel
//   out_valid  out  1        registered valid
//   out_ready  in   1        consumer ready
// ----------------------------------------------------------------------------
module mux_stream_sel
  import mux_stream_sel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2(N),
  parameter int MODE  = MODE_SEL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load_en;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] data_mux;

  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_src_reg;
  logic             out_valid_reg;

  // The output register may take a new word when it is empty or being drained.
  assign load_en = ~out_valid_reg | out_ready;

  generate
    if (MODE == MODE_SEL) begin : g_sel
      // An out-of-range sel matches no channel and therefore grants nothing.
      for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign grant[gi] = in_valid[gi] & (sel == SELW'(gi));
      end
      assign grant_idx = sel;
    end else begin : g_rr
      logic [SELW-1:0] ptr_reg;

      mux_stream_sel_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
      ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .en        (load_en),
        .grant     (grant),
        .grant_idx (grant_idx)
      );

      // Starts at N-1 so channel 0 wins first; moves only on an accepted word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg <= SELW'(N - 1);
        end else if (load_en && grant_any) begin
          ptr_reg <= grant_idx;
        end
      end
    end
  endgenerate

  assign grant_any = |grant;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = grant[gi] & load_en;
  end

  // AND-OR mux keyed by the one-hot grant; avoids indexing with an out-of-range sel.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N; i++) begin
      data_mux = data_mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
    end else if (load_en) begin
      out_valid_reg <= grant_any;
      if (grant_any) begin
        out_data_reg <= data_mux;
        out_src_reg  <= grant_idx;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_stream_sel.sv
// ----------------------------------------------------------------------------
// tb_mux_stream_sel
//   Drives an explicit-select build (N=4), a round-robin build (N=4) and an
//   N=5 explicit-select build. The first two are tracked cycle by cycle by a
//   behavioural model plus an in-order scoreboard of accepted words.
// ----------------------------------------------------------------------------
module tb_mux_stream_sel;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  // Index 0: MODE 0 build, index 1: MODE 1 build
  logic [4*W-1:0] in_data   [2];
  logic [3:0]     in_valid  [2];
  logic [3:0]     in_ready  [2];
  logic [1:0]     sel       [2];
  logic [W-1:0]   out_data  [2];
  logic [1:0]     out_src   [2];
  logic           out_valid [2];
  logic           out_ready [2];

  // N=5 build
  logic [5*W-1:0] e_in_data;
  logic [4:0]     e_in_valid;
  logic [4:0]     e_in_ready;
  logic [2:0]     e_sel;
  logic [W-1:0]   e_out_data;
  logic [2:0]     e_out_src;
  logic           e_out_valid;
  logic           e_out_ready;

  int n_checks;
  int n_errors;

  // Reference model state
  bit           m_valid [2];
  logic [W-1:0] m_data  [2];
  int           m_src   [2];
  int           m_last  [2];
  logic [35:0]  sb_sel [$];
  logic [35:0]  sb_rr  [$];

  mux_stream_sel #(.WIDTH(W), .N(4), .SELW(2), .MODE(0)) u_dut_sel (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sel(sel[0]),
    .out_data(out_data[0]), .out_src(out_src[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0])
  );

  mux_stream_sel #(.WIDTH(W), .N(4), .SELW(2), .MODE(1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sel(sel[1]),
    .out_data(out_data[1]), .out_src(out_src[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1])
  );

  mux_stream_sel #(.WIDTH(W), .N(5), .SELW(3), .MODE(0)) u_dut_n5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(e_in_data), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .sel(e_sel),
    .out_data(e_out_data), .out_src(e_out_src), .out_valid(e_out_valid),
    .out_ready(e_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Which channel the rules pick this cycle (-1 = none), ignoring back-pressure.
  function automatic int model_pick(input int mode, input logic [3:0] v, input int s, input int last);
    if (mode == 0) begin
      if (s < 4 && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = '0;
      m_src[m]   = 0;
      m_last[m]  = 3;
    end
    sb_sel.delete();
    sb_rr.delete();
  endfunction

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic run_cycle();
    int          acc [2];
    logic [35:0] word;
    bit          nonempty;
    #1;
    for (int m = 0; m < 2; m++) begin
      acc[m] = (!m_valid[m] || out_ready[m]) ?
               model_pick(m, in_valid[m], int'(sel[m]), m_last[m]) : -1;
      check($sformatf("in_ready_%0d", m), 64'(in_ready[m]),
            (acc[m] >= 0) ? (64'd1 << acc[m]) : 64'd0);
      check($sformatf("onehot_%0d", m), 64'($countones(in_ready[m]) <= 1), 64'd1);
      if (out_valid[m] && out_ready[m]) begin
        nonempty = (m == 0) ? (sb_sel.size() != 0) : (sb_rr.size() != 0);
        check($sformatf("sb_nonempty_%0d", m), 64'(nonempty), 64'd1);
        if (nonempty) begin
          if (m == 0) word = sb_sel.pop_front();
          else        word = sb_rr.pop_front();
          check($sformatf("sb_order_%0d", m), 64'({2'b00, out_src[m], out_data[m]}), 64'(word));
          $display("dut%0d deliver src=%0d data=%08h", m, out_src[m], out_data[m]);
        end
      end
      if (acc[m] >= 0) begin
        word = {4'(acc[m]), in_data[m][acc[m]*W +: W]};
        if (m == 0) sb_sel.push_back(word);
        else        sb_rr.push_back(word);
      end
      if (!m_valid[m] || out_ready[m]) begin
        m_valid[m] = (acc[m] >= 0);
        if (acc[m] >= 0) begin
          m_data[m] = in_data[m][acc[m]*W +: W];
          m_src[m]  = acc[m];
          m_last[m] = acc[m];
        end
      end
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("out_valid_%0d", m), 64'(out_valid[m]), 64'(m_valid[m]));
      check($sformatf("out_data_%0d", m), 64'(out_data[m]), 64'(m_data[m]));
      check($sformatf("out_src_%0d", m), 64'(out_src[m]), 64'(m_src[m]));
    end
  endtask

  initial begin
    logic [W-1:0] exp_w;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    for (int m = 0; m < 2; m++) begin
      in_data[m]   = '0;
      in_valid[m]  = '0;
      sel[m]       = '0;
      out_ready[m] = 1'b1;
    end
    e_in_data   = '0;
    e_in_valid  = '0;
    e_sel       = '0;
    e_out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check("rst_valid", 64'(out_valid[m]), 64'd0);
      check("rst_data", 64'(out_data[m]), 64'd0);
      check("rst_src", 64'(out_src[m]), 64'd0);
    end
    check("rst_n5_valid", 64'(e_out_valid), 64'd0);
    rst_n = 1'b1;

    // Explicit select of channel 2
    in_valid[0] = 4'b0100;
    sel[0]      = 2'd2;
    in_data[0][2*W +: W] = 32'hDEADBEEF;
    #1 check("sel2_in_ready", 64'(in_ready[0]), 64'h4);
    run_cycle();
    check("sel2_data", 64'(out_data[0]), 64'hDEADBEEF);
    check("sel2_src", 64'(out_src[0]), 64'd2);
    check("sel2_valid", 64'(out_valid[0]), 64'd1);
    $display("sel2 load src=%0d data=%08h", out_src[0], out_data[0]);
    sel[0] = 2'd3;
    run_cycle();
    check("sel3_novalid", 64'(out_valid[0]), 64'd0);
    in_valid[0] = '0;

    // Round-robin, all valid, no bubbles
    for (int i = 0; i < 4; i++) in_data[1][i*W +: W] = 32'hC0DE0000 | 32'(i);
    in_valid[1] = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      check("rr_seq_src", 64'(out_src[1]), 64'(k % 4));
      check("rr_seq_valid", 64'(out_valid[1]), 64'd1);
    end

    // Back-pressure: held word stays, no ready, pointer frozen
    out_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[1] = {$urandom, $urandom, $urandom, $urandom};
      #1 check("stall_in_ready", 64'(in_ready[1]), 64'd0);
      run_cycle();
      check("stall_data", 64'(out_data[1]), 64'hC0DE0003);
      check("stall_src", 64'(out_src[1]), 64'd3);
      check("stall_valid", 64'(out_valid[1]), 64'd1);
      $display("stall cycle %0d src=%0d", k, out_src[1]);
    end
    out_ready[1] = 1'b1;
    exp_w = in_data[1][0 +: W];
    run_cycle();
    check("unstall_src", 64'(out_src[1]), 64'd0);
    check("unstall_data", 64'(out_data[1]), 64'(exp_w));

    // Wrap from channel 3 back to 0
    in_valid[1] = 4'b1000;
    run_cycle();
    check("wrap_src3", 64'(out_src[1]), 64'd3);
    in_valid[1] = 4'b1001;
    run_cycle();
    check("wrap_src0", 64'(out_src[1]), 64'd0);
    run_cycle();
    check("wrap_src3b", 64'(out_src[1]), 64'd3);
    in_valid[1] = '0;

    // N=5 build: channel 4 in range, sel=5 out of range
    e_in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e_in_data[4*W +: W] = 32'hCAFEF00D;
    e_in_valid  = 5'b11111;
    e_sel       = 3'd4;
    #1 check("n5_sel4_ready", 64'(e_in_ready), 64'h10);
    run_cycle();
    check("n5_sel4_valid", 64'(e_out_valid), 64'd1);
    check("n5_sel4_data", 64'(e_out_data), 64'hCAFEF00D);
    check("n5_sel4_src", 64'(e_out_src), 64'd4);
    $display("n5 load src=%0d data=%08h", e_out_src, e_out_data);
    e_sel = 3'd5;
    e_in_data[4*W +: W] = 32'h12345678;
    #1 check("n5_sel5_ready", 64'(e_in_ready), 64'd0);
    run_cycle();
    check("n5_sel5_valid", 64'(e_out_valid), 64'd0);
    check("n5_sel5_hold_data", 64'(e_out_data), 64'hCAFEF00D);
    check("n5_sel5_hold_src", 64'(e_out_src), 64'd4);
    e_in_valid = '0;

    // Reset while words are held under back-pressure
    in_valid[0]  = 4'b0010;
    sel[0]       = 2'd1;
    in_valid[1]  = 4'b1111;
    run_cycle();
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    run_cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("midrst_valid", 64'(out_valid[m]), 64'd0);
      check("midrst_data", 64'(out_data[m]), 64'd0);
      check("midrst_src", 64'(out_src[m]), 64'd0);
    end
    $display("mid-stream reset applied");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid[0]  = '0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    in_valid[1]  = 4'b1111;
    run_cycle();
    check("postrst_first_src", 64'(out_src[1]), 64'd0);
    check("postrst_first_valid", 64'(out_valid[1]), 64'd1);

    // Randomised traffic against the model and scoreboard
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        in_data[m]   = {$urandom, $urandom, $urandom, $urandom};
        in_valid[m]  = 4'($urandom);
        sel[m]       = 2'($urandom);
        out_ready[m] = ($urandom_range(0, 9) < 7);
      end
      run_cycle();
    end

    // Drain and confirm nothing was lost
    for (int m = 0; m < 2; m++) begin
      in_valid[m]  = '0;
      out_ready[m] = 1'b1;
    end
    repeat (3) run_cycle();
    check("drain_sel", 64'(sb_sel.size()), 64'd0);
    check("drain_rr", 64'(sb_rr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
